// File: rtl/nanorv32_tcm_xbar_pkg.sv
// Shared constants and helpers for the nanorv32 TCM crossbar and its bank arbiters.
// Optional build macro: NANORV32_XBAR_RR_EN (round-robin collision arbitration).
package nanorv32_tcm_xbar_pkg;

    localparam int XBAR_M_CODE     = 0;
    localparam int XBAR_M_DATA     = 1;
    localparam int XBAR_NB_MASTERS = 2;

    typedef enum logic {
        M_CODE = 1'b0,
        M_DATA = 1'b1
    } xbar_master_e;

    function automatic int xbar_bsw(input int nb_banks);
        return (nb_banks <= 2) ? 1 : $clog2(nb_banks);
    endfunction

    // Source register must also encode the error source, one past the last bank.
    function automatic int xbar_srcw(input int nb_banks);
        return $clog2(nb_banks + 1);
    endfunction

    function automatic int xbar_err_src(input int nb_banks);
        return nb_banks;
    endfunction

endpackage

// File: rtl/nanorv32_xbar_bank_arb.sv
// Two-master arbiter for one TCM bank: data-first fixed priority, or a
// last-winner pointer when NANORV32_XBAR_RR_EN is defined.
module nanorv32_xbar_bank_arb
    import nanorv32_tcm_xbar_pkg::*;
(
`ifdef NANORV32_XBAR_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic req_code,
    input  logic req_data,
    input  logic ready_nxt,
    output logic gnt_code,
    output logic gnt_data,
    output logic ack_code,
    output logic ack_data
);

    logic code_first;

`ifdef NANORV32_XBAR_RR_EN
    xbar_master_e last_r;

    assign code_first = (last_r == M_DATA);

    // Pointer only moves when a contended grant is actually taken by the bank,
    // so a stalled bank keeps the same winner until it accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= M_CODE;
        end else if (req_code && req_data && ready_nxt) begin
            last_r <= gnt_code ? M_CODE : M_DATA;
        end
    end
`else
    assign code_first = 1'b0;
`endif

    assign gnt_data = req_data & ~(req_code & code_first);
    assign gnt_code = req_code & (~req_data | code_first);
    assign ack_code = gnt_code & ready_nxt;
    assign ack_data = gnt_data & ready_nxt;

endmodule

// File: rtl/nanorv32_tcm_xbar.sv
// Code/data crossbar onto NB_BANKS single-port TCM banks with decode-error responses.
// Optional build macro: NANORV32_XBAR_RR_EN (round-robin collisions instead of data-first).
module nanorv32_tcm_xbar
    import nanorv32_tcm_xbar_pkg::*;
#(
    parameter int NB_BANKS     = 2,
    parameter int AW           = 13,
    parameter int BANK_SEL_LSB = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            cpu_codeif_addr,
    input  logic                   cpu_codeif_req,
    output logic [31:0]            codeif_cpu_rdata,
    output logic                   codeif_cpu_early_ready,
    output logic                   codeif_cpu_ready_r,
    input  logic [31:0]            cpu_dataif_addr,
    input  logic [31:0]            cpu_dataif_wdata,
    input  logic [3:0]             cpu_dataif_bytesel,
    input  logic                   cpu_dataif_req,
    output logic [31:0]            dataif_cpu_rdata,
    output logic                   dataif_cpu_early_ready,
    output logic                   dataif_cpu_ready_r,
    output logic [NB_BANKS-1:0]    bank_en,
    output logic [NB_BANKS*AW-1:0] bank_addr,
    output logic [NB_BANKS*32-1:0] bank_din,
    output logic [NB_BANKS*4-1:0]  bank_bytesel,
    input  logic [NB_BANKS*32-1:0] bank_dout,
    input  logic [NB_BANKS-1:0]    bank_ready_nxt,
    output logic                   xbar_decerr_r
);

    localparam int BSW  = xbar_bsw(NB_BANKS);
    localparam int SRCW = xbar_srcw(NB_BANKS);
    localparam logic [SRCW-1:0] ERR_SRC = SRCW'(xbar_err_src(NB_BANKS));
    localparam logic [BSW:0]    NB_EXT  = (BSW+1)'(NB_BANKS);

    logic [31:0]                m_addr    [XBAR_NB_MASTERS];
    logic [BSW-1:0]             m_idx     [XBAR_NB_MASTERS];
    logic [AW-1:0]              m_word    [XBAR_NB_MASTERS];
    logic [SRCW-1:0]            m_src_nxt [XBAR_NB_MASTERS];
    logic [SRCW-1:0]            src_r     [XBAR_NB_MASTERS];
    logic [31:0]                m_rdata   [XBAR_NB_MASTERS];
    logic [XBAR_NB_MASTERS-1:0] m_req;
    logic [XBAR_NB_MASTERS-1:0] m_err;
    logic [XBAR_NB_MASTERS-1:0] m_early;
    logic [XBAR_NB_MASTERS-1:0] ready_r;

    logic [NB_BANKS-1:0] hit_code;
    logic [NB_BANKS-1:0] hit_data;
    logic [NB_BANKS-1:0] gnt_code;
    logic [NB_BANKS-1:0] gnt_data;
    logic [NB_BANKS-1:0] ack_code;
    logic [NB_BANKS-1:0] ack_data;

    assign m_addr[XBAR_M_CODE] = cpu_codeif_addr;
    assign m_addr[XBAR_M_DATA] = cpu_dataif_addr;
    assign m_req[XBAR_M_CODE]  = cpu_codeif_req;
    assign m_req[XBAR_M_DATA]  = cpu_dataif_req;

    // Anything outside the bank window, including high address bits, is an error
    // rather than an alias of a real bank.
    always_comb begin
        for (int m = 0; m < XBAR_NB_MASTERS; m++) begin
            m_idx[m]     = m_addr[m][BANK_SEL_LSB +: BSW];
            m_word[m]    = m_addr[m][AW+1:2];
            m_err[m]     = ({1'b0, m_idx[m]} >= NB_EXT) ||
                           ((m_addr[m] >> (BANK_SEL_LSB + BSW)) != 32'h0);
            m_src_nxt[m] = m_err[m] ? ERR_SRC : SRCW'(m_idx[m]);
        end
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        assign hit_code[b] = m_req[XBAR_M_CODE] & ~m_err[XBAR_M_CODE] &
                             (m_idx[XBAR_M_CODE] == BSW'(b));
        assign hit_data[b] = m_req[XBAR_M_DATA] & ~m_err[XBAR_M_DATA] &
                             (m_idx[XBAR_M_DATA] == BSW'(b));

        nanorv32_xbar_bank_arb u_arb (
`ifdef NANORV32_XBAR_RR_EN
            .clk       (clk),
            .rst_n     (rst_n),
`endif
            .req_code  (hit_code[b]),
            .req_data  (hit_data[b]),
            .ready_nxt (bank_ready_nxt[b]),
            .gnt_code  (gnt_code[b]),
            .gnt_data  (gnt_data[b]),
            .ack_code  (ack_code[b]),
            .ack_data  (ack_data[b])
        );

        assign bank_en[b]               = gnt_code[b] | gnt_data[b];
        assign bank_addr[b*AW +: AW]    = gnt_data[b] ? m_word[XBAR_M_DATA] :
                                          gnt_code[b] ? m_word[XBAR_M_CODE] : '0;
        assign bank_din[b*32 +: 32]     = gnt_data[b] ? cpu_dataif_wdata : 32'h0;
        assign bank_bytesel[b*4 +: 4]   = gnt_data[b] ? cpu_dataif_bytesel : 4'h0;
    end

    // A decode error is accepted at once so the CPU never stalls on a bad address.
    assign m_early[XBAR_M_CODE] = m_req[XBAR_M_CODE] & (m_err[XBAR_M_CODE] | (|ack_code));
    assign m_early[XBAR_M_DATA] = m_req[XBAR_M_DATA] & (m_err[XBAR_M_DATA] | (|ack_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r       <= '0;
            xbar_decerr_r <= 1'b0;
            for (int m = 0; m < XBAR_NB_MASTERS; m++) begin
                src_r[m] <= '0;
            end
        end else begin
            ready_r       <= m_early;
            xbar_decerr_r <= |(m_req & m_err);
            for (int m = 0; m < XBAR_NB_MASTERS; m++) begin
                src_r[m] <= m_src_nxt[m];
            end
        end
    end

    // The error source matches no bank, so it falls through to zero data.
    always_comb begin
        for (int m = 0; m < XBAR_NB_MASTERS; m++) begin
            m_rdata[m] = 32'h0;
            for (int b = 0; b < NB_BANKS; b++) begin
                if (ready_r[m] && (src_r[m] == SRCW'(b))) begin
                    m_rdata[m] = bank_dout[b*32 +: 32];
                end
            end
        end
    end

    assign codeif_cpu_early_ready = m_early[XBAR_M_CODE];
    assign dataif_cpu_early_ready = m_early[XBAR_M_DATA];
    assign codeif_cpu_ready_r     = ready_r[XBAR_M_CODE];
    assign dataif_cpu_ready_r     = ready_r[XBAR_M_DATA];
    assign codeif_cpu_rdata       = m_rdata[XBAR_M_CODE];
    assign dataif_cpu_rdata       = m_rdata[XBAR_M_DATA];

endmodule

// File: tb/tb_nanorv32_tcm_xbar.sv
// Self-checking bench for nanorv32_tcm_xbar: directed cases then randomized traffic
// against an address-level reference model. Honours NANORV32_XBAR_RR_EN.
module tb_nanorv32_tcm_xbar;

    localparam int NB  = 2;
    localparam int AW  = 13;
    localparam int LSB = 15;
`ifdef NANORV32_XBAR_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      cpu_codeif_addr;
    logic             cpu_codeif_req;
    logic [31:0]      codeif_cpu_rdata;
    logic             codeif_cpu_early_ready;
    logic             codeif_cpu_ready_r;
    logic [31:0]      cpu_dataif_addr;
    logic [31:0]      cpu_dataif_wdata;
    logic [3:0]       cpu_dataif_bytesel;
    logic             cpu_dataif_req;
    logic [31:0]      dataif_cpu_rdata;
    logic             dataif_cpu_early_ready;
    logic             dataif_cpu_ready_r;
    logic [NB-1:0]    bank_en;
    logic [NB*AW-1:0] bank_addr;
    logic [NB*32-1:0] bank_din;
    logic [NB*4-1:0]  bank_bytesel;
    logic [NB*32-1:0] bank_dout;
    logic [NB-1:0]    bank_ready_nxt;
    logic             xbar_decerr_r;

    int total = 0;
    int bad   = 0;

    // Reference model state: memory contents per bank/word and collision priority.
    logic [31:0] ref_mem [NB][16];
    logic [NB-1:0] code_prio;

    // Simple TCM fixture: only the low 4 word-address bits are backed.
    logic [31:0] bank_mem [NB][16];
    logic        fix_load;

    always #5 clk = ~clk;

    nanorv32_tcm_xbar #(.NB_BANKS(NB), .AW(AW), .BANK_SEL_LSB(LSB)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cpu_codeif_addr        (cpu_codeif_addr),
        .cpu_codeif_req         (cpu_codeif_req),
        .codeif_cpu_rdata       (codeif_cpu_rdata),
        .codeif_cpu_early_ready (codeif_cpu_early_ready),
        .codeif_cpu_ready_r     (codeif_cpu_ready_r),
        .cpu_dataif_addr        (cpu_dataif_addr),
        .cpu_dataif_wdata       (cpu_dataif_wdata),
        .cpu_dataif_bytesel     (cpu_dataif_bytesel),
        .cpu_dataif_req         (cpu_dataif_req),
        .dataif_cpu_rdata       (dataif_cpu_rdata),
        .dataif_cpu_early_ready (dataif_cpu_early_ready),
        .dataif_cpu_ready_r     (dataif_cpu_ready_r),
        .bank_en                (bank_en),
        .bank_addr              (bank_addr),
        .bank_din               (bank_din),
        .bank_bytesel           (bank_bytesel),
        .bank_dout              (bank_dout),
        .bank_ready_nxt         (bank_ready_nxt),
        .xbar_decerr_r          (xbar_decerr_r)
    );

    function automatic logic [31:0] init_val(input int b, input int w);
        return 32'hC0DE_0000 ^ (32'(b) << 28) ^ (32'(w) * 32'h0103_0507);
    endfunction

    always @(posedge clk) begin
        if (fix_load) begin
            bank_dout <= '0;
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < 16; w++)
                    bank_mem[b][w] <= init_val(b, w);
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_en[b] && bank_ready_nxt[b]) begin
                    bank_dout[b*32 +: 32] <= bank_mem[b][bank_addr[b*AW +: 4]];
                    for (int k = 0; k < 4; k++)
                        if (bank_bytesel[b*4+k])
                            bank_mem[b][bank_addr[b*AW +: 4]][8*k +: 8] <= bank_din[b*32+8*k +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One bus cycle: drive, check the combinational response, clock, check the registered response.
    task automatic applyStimulus(input logic creq, input logic [31:0] caddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input logic [31:0] wdata, input logic [3:0] bsel,
                                 input logic [NB-1:0] rdy,
                                 output logic c_acc, output logic d_acc);
        logic c_err, d_err, c_val, d_val, collide, code_wins, c_gnt, d_gnt;
        logic exp_c_er, exp_d_er, d_write;
        int c_bank, d_bank;
        logic [AW-1:0] c_word, d_word;
        logic [NB-1:0] exp_en;
        logic [NB*AW-1:0] exp_addr;
        logic [NB*32-1:0] exp_din;
        logic [NB*4-1:0] exp_bsel;
        logic [31:0] exp_c_rd, exp_d_rd;

        @(negedge clk);
        cpu_codeif_req     = creq;
        cpu_codeif_addr    = caddr;
        cpu_dataif_req     = dreq;
        cpu_dataif_addr    = daddr;
        cpu_dataif_wdata   = wdata;
        cpu_dataif_bytesel = bsel;
        bank_ready_nxt     = rdy;
        #1;

        c_bank = int'(caddr >> LSB);
        d_bank = int'(daddr >> LSB);
        c_word = AW'(caddr >> 2);
        d_word = AW'(daddr >> 2);
        c_err  = creq && (c_bank >= NB);
        d_err  = dreq && (d_bank >= NB);
        c_val  = creq && !c_err;
        d_val  = dreq && !d_err;
        collide   = c_val && d_val && (c_bank == d_bank);
        code_wins = 1'b0;
        if (collide) code_wins = RR_EN && code_prio[c_bank];
        c_gnt = c_val && (!collide || code_wins);
        d_gnt = d_val && (!collide || !code_wins);

        exp_c_er = c_err;
        if (c_gnt) exp_c_er = rdy[c_bank];
        exp_d_er = d_err;
        if (d_gnt) exp_d_er = rdy[d_bank];

        exp_en = '0; exp_addr = '0; exp_din = '0; exp_bsel = '0;
        for (int b = 0; b < NB; b++) begin
            if (d_gnt && d_bank == b) begin
                exp_en[b] = 1'b1;
                exp_addr[b*AW +: AW] = d_word;
                exp_din[b*32 +: 32]  = wdata;
                exp_bsel[b*4 +: 4]   = bsel;
            end else if (c_gnt && c_bank == b) begin
                exp_en[b] = 1'b1;
                exp_addr[b*AW +: AW] = c_word;
            end
        end

        checkOutput("code_early_ready", 64'(codeif_cpu_early_ready), 64'(exp_c_er));
        checkOutput("data_early_ready", 64'(dataif_cpu_early_ready), 64'(exp_d_er));
        checkOutput("bank_en", 64'(bank_en), 64'(exp_en));
        checkOutput("bank_addr", 64'(bank_addr), 64'(exp_addr));
        checkOutput("bank_din", 64'(bank_din), 64'(exp_din));
        checkOutput("bank_bytesel", 64'(bank_bytesel), 64'(exp_bsel));

        exp_c_rd = 32'h0;
        if (c_gnt && rdy[c_bank]) exp_c_rd = ref_mem[c_bank][c_word[3:0]];
        exp_d_rd = 32'h0;
        d_write  = 1'b0;
        if (d_gnt && rdy[d_bank]) begin
            d_write  = (bsel != 4'h0);
            exp_d_rd = ref_mem[d_bank][d_word[3:0]];
        end

        @(posedge clk);
        #1;
        checkOutput("code_ready_r", 64'(codeif_cpu_ready_r), 64'(exp_c_er));
        checkOutput("code_rdata", 64'(codeif_cpu_rdata), 64'(exp_c_rd));
        checkOutput("data_ready_r", 64'(dataif_cpu_ready_r), 64'(exp_d_er));
        if (!d_write) checkOutput("data_rdata", 64'(dataif_cpu_rdata), 64'(exp_d_rd));
        checkOutput("decerr_r", 64'(xbar_decerr_r), 64'(c_err || d_err));

        if (d_write)
            for (int k = 0; k < 4; k++)
                if (bsel[k]) ref_mem[d_bank][d_word[3:0]][8*k +: 8] = wdata[8*k +: 8];
        if (collide && rdy[c_bank]) code_prio[c_bank] = !code_wins;

        c_acc = exp_c_er;
        d_acc = exp_d_er;
    endtask

    function automatic logic [31:0] gen_addr();
        int sel = $urandom_range(0, 11);
        logic [31:0] w = 32'($urandom_range(0, 15)) << 2;
        if (sel == 0) return 32'h0001_0000 | w;
        if (sel == 1) return 32'h8000_8000 | w;
        return (32'($urandom_range(0, NB-1)) << LSB) | w | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic c_acc, d_acc, cr, dr;
        logic [31:0] ca, da, wd;
        logic [3:0] bs;
        logic [NB-1:0] rdy;

        rst_n              = 1'b0;
        cpu_codeif_req     = 1'b0;
        cpu_codeif_addr    = 32'h0;
        cpu_dataif_req     = 1'b0;
        cpu_dataif_addr    = 32'h0;
        cpu_dataif_wdata   = 32'h0;
        cpu_dataif_bytesel = 4'h0;
        bank_ready_nxt     = '1;
        fix_load           = 1'b1;
        code_prio          = '0;
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 16; w++)
                ref_mem[b][w] = init_val(b, w);

        @(posedge clk);
        #1 fix_load = 1'b0;
        checkOutput("reset_code_ready_r", 64'(codeif_cpu_ready_r), 64'h0);
        checkOutput("reset_data_ready_r", 64'(dataif_cpu_ready_r), 64'h0);
        checkOutput("reset_decerr_r", 64'(xbar_decerr_r), 64'h0);
        checkOutput("reset_bank_en", 64'(bank_en), 64'h0);
        checkOutput("reset_rdata", {codeif_cpu_rdata, dataif_cpu_rdata}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] parallel fetch and load on different banks");
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0000_8004, 32'h0, 4'h0, 2'b11, c_acc, d_acc);

        $display("[TB] collisions on bank 0");
        applyStimulus(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0024, 32'h0, 4'h0, 2'b11, c_acc, d_acc);
        applyStimulus(1'b1, 32'h0000_0020, 1'b0, 32'h0, 32'h0, 4'h0, 2'b11, c_acc, d_acc);
        applyStimulus(1'b1, 32'h0000_0030, 1'b1, 32'h0000_0028, 32'h0, 4'h0, 2'b11, c_acc, d_acc);
        applyStimulus(1'b1, 32'h0000_0030, 1'b1, 32'h0000_0028, 32'h0, 4'h0, 2'b11, c_acc, d_acc);

        $display("[TB] partial store then load");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_8008, 32'hDEAD_BEEF, 4'b0011, 2'b11, c_acc, d_acc);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_8008, 32'h0, 4'h0, 2'b11, c_acc, d_acc);

        $display("[TB] decode errors");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0001_0000, 32'h1234_5678, 4'hF, 2'b11, c_acc, d_acc);
        applyStimulus(1'b1, 32'h0000_0000, 1'b1, 32'h0000_8000, 32'h0, 4'h0, 2'b11, c_acc, d_acc);
        applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h0001_0004, 32'h0, 4'h0, 2'b11, c_acc, d_acc);

        $display("[TB] bank stall");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_800C, 32'h0, 4'h0, 2'b01, c_acc, d_acc);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_800C, 32'h0, 4'h0, 2'b11, c_acc, d_acc);

        $display("[TB] reset mid-access");
        applyStimulus(1'b1, 32'h0000_0014, 1'b0, 32'h0, 32'h0, 4'h0, 2'b11, c_acc, d_acc);
        cpu_codeif_req = 1'b0;
        rst_n          = 1'b0;
        code_prio      = '0;
        #1;
        checkOutput("midrst_code_ready_r", 64'(codeif_cpu_ready_r), 64'h0);
        checkOutput("midrst_code_rdata", 64'(codeif_cpu_rdata), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b11, c_acc, d_acc);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b11, c_acc, d_acc);

        $display("[TB] randomized traffic");
        cr = 1'b0;
        dr = 1'b0;
        ca = 32'h0;
        da = 32'h0;
        wd = 32'h0;
        bs = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if (!cr) begin
                cr = ($urandom_range(0, 3) != 0);
                ca = gen_addr();
            end
            if (!dr) begin
                dr = ($urandom_range(0, 3) != 0);
                da = gen_addr();
                wd = $urandom();
                bs = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            for (int b = 0; b < NB; b++) rdy[b] = ($urandom_range(0, 3) != 0);
            applyStimulus(cr, ca, dr, da, wd, bs, rdy, c_acc, d_acc);
            if (c_acc) cr = 1'b0;
            if (d_acc) dr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
